// File: rtl/vis_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : vis_accumulator_if
// Description : Partial-sum input stream and integrated-visibility output
//               stream of the visibility accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface vis_accumulator_if #(
    parameter int ABITS = 6,
    parameter int VBITS = 24,
    parameter int NBITS = 4
);
    logic [ABITS-1:0] revis_i;
    logic [ABITS-1:0] imvis_i;
    logic             valid_i;
    logic             ready_o;
    logic [VBITS-1:0] revis_o;
    logic [VBITS-1:0] imvis_o;
    logic [NBITS-1:0] addr_o;
    logic             last_o;
    logic             valid_o;
    logic             ready_i;
    logic             overflow_o;

    modport slave (
        input  revis_i, imvis_i, valid_i, ready_i,
        output ready_o, revis_o, imvis_o, addr_o, last_o, valid_o, overflow_o
    );

    modport master (
        output revis_i, imvis_i, valid_i, ready_i,
        input  ready_o, revis_o, imvis_o, addr_o, last_o, valid_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/vis_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : vis_accumulator
// Description : Integrates LOOPS frames of NVIS complex partial sums per slot
//               and streams the integrated visibilities out. Optional
//               saturating adds with sticky overflow: VIS_ACCUMULATOR_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vis_accumulator #(
    parameter int ABITS = 6,
    parameter int VBITS = 24,
    parameter int NVIS  = 15,
    parameter int NBITS = 4,
    parameter int LOOPS = 64,
    parameter int LBITS = 7
) (
    input wire               clock_i,
    input wire               reset_i,
    vis_accumulator_if.slave bus
);
    localparam logic             c_ST_ACCUM    = 1'b0;
    localparam logic             c_ST_DRAIN    = 1'b1;
    localparam logic             c_RESET_STATE = (LOOPS == 1) ? c_ST_DRAIN : c_ST_ACCUM;
    localparam logic [NBITS-1:0] c_LAST_SLOT   = NBITS'(NVIS - 1);
    localparam logic [LBITS-1:0] c_LAST_FRAME  = LBITS'(LOOPS - 1);

    logic             r_state;
    logic             w_state_next;
    logic [NBITS-1:0] r_slot;
    logic [NBITS-1:0] w_slot_next;
    logic [LBITS-1:0] r_frame;
    logic [LBITS-1:0] w_frame_next;
    logic             w_ready;
    logic             w_xfer;

    logic signed [VBITS-1:0] r_mem_re [NVIS];
    logic signed [VBITS-1:0] r_mem_im [NVIS];

    logic signed [VBITS-1:0] w_ext_re, w_ext_im;
    logic signed [VBITS-1:0] w_base_re, w_base_im;
    logic signed [VBITS-1:0] w_acc_re, w_acc_im;
    logic signed [VBITS-1:0] w_out_re, w_out_im;

    logic signed [VBITS-1:0] r_revis, r_imvis;
    logic [NBITS-1:0]        r_addr;
    logic                    r_last;
    logic                    r_valid;

`ifdef VIS_ACCUMULATOR_SATURATE_EN
    localparam logic signed [VBITS-1:0] c_MAX = {1'b0, {(VBITS-1){1'b1}}};
    localparam logic signed [VBITS-1:0] c_MIN = {1'b1, {(VBITS-1){1'b0}}};

    function automatic logic signed [VBITS-1:0] f_add(input logic signed [VBITS-1:0] a,
                                                      input logic signed [VBITS-1:0] b);
        logic signed [VBITS:0] s;
        s = {a[VBITS-1], a} + {b[VBITS-1], b};
        if (s[VBITS] != s[VBITS-1]) return s[VBITS] ? c_MIN : c_MAX;
        return s[VBITS-1:0];
    endfunction

    function automatic logic f_ovf(input logic signed [VBITS-1:0] a,
                                   input logic signed [VBITS-1:0] b);
        logic signed [VBITS:0] s;
        s = {a[VBITS-1], a} + {b[VBITS-1], b};
        return s[VBITS] != s[VBITS-1];
    endfunction
`else
    function automatic logic signed [VBITS-1:0] f_add(input logic signed [VBITS-1:0] a,
                                                      input logic signed [VBITS-1:0] b);
        return a + b;
    endfunction
`endif

    assign w_ext_re  = {{(VBITS-ABITS){bus.revis_i[ABITS-1]}}, bus.revis_i};
    assign w_ext_im  = {{(VBITS-ABITS){bus.imvis_i[ABITS-1]}}, bus.imvis_i};
    // With a single loop the drain frame is also frame 0, so mem holds nothing useful.
    assign w_base_re = (LOOPS == 1) ? '0 : r_mem_re[r_slot];
    assign w_base_im = (LOOPS == 1) ? '0 : r_mem_im[r_slot];
    assign w_acc_re  = f_add(r_mem_re[r_slot], w_ext_re);
    assign w_acc_im  = f_add(r_mem_im[r_slot], w_ext_im);
    assign w_out_re  = f_add(w_base_re, w_ext_re);
    assign w_out_im  = f_add(w_base_im, w_ext_im);
    assign w_xfer    = bus.valid_i && w_ready;

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= c_RESET_STATE;
            r_slot  <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_next;
            r_slot  <= w_slot_next;
            r_frame <= w_frame_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_slot_next  = r_slot;
        w_frame_next = r_frame;
        if (w_xfer) begin
            if (r_slot == c_LAST_SLOT) begin
                w_slot_next  = '0;
                w_frame_next = (r_frame == c_LAST_FRAME) ? '0 : r_frame + 1'b1;
            end else begin
                w_slot_next = r_slot + 1'b1;
            end
        end
        w_state_next = (w_frame_next == c_LAST_FRAME) ? c_ST_DRAIN : c_ST_ACCUM;
    end

    // Output logic
    always_comb begin
        w_ready = 1'b1;
        if (r_state == c_ST_DRAIN) w_ready = !r_valid || bus.ready_i;
    end

    always_ff @(posedge clock_i) begin
        if (w_xfer && r_state == c_ST_ACCUM) begin
            r_mem_re[r_slot] <= (r_frame == '0) ? w_ext_re : w_acc_re;
            r_mem_im[r_slot] <= (r_frame == '0) ? w_ext_im : w_acc_im;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_revis <= '0;
            r_imvis <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_xfer && r_state == c_ST_DRAIN) begin
            r_revis <= w_out_re;
            r_imvis <= w_out_im;
            r_addr  <= r_slot;
            r_last  <= (r_slot == c_LAST_SLOT);
            r_valid <= 1'b1;
        end else if (r_valid && bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

`ifdef VIS_ACCUMULATOR_SATURATE_EN
    logic r_overflow;
    logic w_ovf;

    // Frame 0 overwrites without adding, so it can never clamp.
    assign w_ovf = w_xfer && (
        (r_state == c_ST_ACCUM && r_frame != '0 &&
         (f_ovf(r_mem_re[r_slot], w_ext_re) || f_ovf(r_mem_im[r_slot], w_ext_im))) ||
        (r_state == c_ST_DRAIN &&
         (f_ovf(w_base_re, w_ext_re) || f_ovf(w_base_im, w_ext_im))));

    always_ff @(posedge clock_i) begin
        if (reset_i)    r_overflow <= 1'b0;
        else if (w_ovf) r_overflow <= 1'b1;
    end

    assign bus.overflow_o = r_overflow;
`else
    assign bus.overflow_o = 1'b0;
`endif

    assign bus.ready_o = w_ready;
    assign bus.revis_o = r_revis;
    assign bus.imvis_o = r_imvis;
    assign bus.addr_o  = r_addr;
    assign bus.last_o  = r_last;
    assign bus.valid_o = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_vis_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vis_accumulator
// Description : Scoreboard bench for vis_accumulator: randomized main instance
//               plus saturation and single-loop instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vis_accumulator;
    localparam int ABITS   = 6;
    localparam int VBITS   = 24;
    localparam int NVIS    = 4;
    localparam int LOOPS   = 3;
    localparam int VB_B    = 8;
    localparam int NVIS_B  = 2;
    localparam int LOOPS_B = 8;
    localparam int NBLOCKS = 1000;

    typedef struct {
        longint re;
        longint im;
        int     addr;
        bit     last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   blk_re [LOOPS][NVIS];
    int   blk_im [LOOPS][NVIS];
    int   m_cnt    = 0;
    int   m_blocks = 0;

    always #5 clk = ~clk;

    vis_accumulator_if #(.ABITS(ABITS), .VBITS(VBITS), .NBITS(2)) bus_a ();
    vis_accumulator_if #(.ABITS(ABITS), .VBITS(VB_B),  .NBITS(1)) bus_b ();
    vis_accumulator_if #(.ABITS(ABITS), .VBITS(VBITS), .NBITS(1)) bus_c ();

    vis_accumulator #(.ABITS(ABITS), .VBITS(VBITS), .NVIS(NVIS), .NBITS(2),
                      .LOOPS(LOOPS), .LBITS(2))
        u_dut_a (.clock_i(clk), .reset_i(rst), .bus(bus_a));
    vis_accumulator #(.ABITS(ABITS), .VBITS(VB_B), .NVIS(NVIS_B), .NBITS(1),
                      .LOOPS(LOOPS_B), .LBITS(3))
        u_dut_b (.clock_i(clk), .reset_i(rst), .bus(bus_b));
    vis_accumulator #(.ABITS(ABITS), .VBITS(VBITS), .NVIS(2), .NBITS(1),
                      .LOOPS(1), .LBITS(1))
        u_dut_c (.clock_i(clk), .reset_i(rst), .bus(bus_c));

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Signed add of two VB-bit quantities: clamped or wrapped, as configured.
    function automatic longint f_model_add(input longint a, input longint b, input int vb);
        longint s, hi, lo, one;
        one = 1;
        s   = a + b;
        hi  = (one <<< (vb - 1)) - 1;
        lo  = -(one <<< (vb - 1));
`ifdef VIS_ACCUMULATOR_SATURATE_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        s = s & ((one <<< vb) - 1);
        if (s > hi) s = s - (one <<< vb);
`endif
        return s;
    endfunction

    function automatic bit model_drain();
        return (m_cnt / NVIS) == LOOPS - 1;
    endfunction

    // Records an accepted word; on the last frame the slot's block total is due out.
    task automatic model_accept(input int re, input int im);
        int f, s;
        exp_t e;
        f = m_cnt / NVIS;
        s = m_cnt % NVIS;
        blk_re[f][s] = re;
        blk_im[f][s] = im;
        if (f == LOOPS - 1) begin
            e.re = blk_re[0][s];
            e.im = blk_im[0][s];
            for (int k = 1; k < LOOPS; k++) begin
                e.re = f_model_add(e.re, blk_re[k][s], VBITS);
                e.im = f_model_add(e.im, blk_im[k][s], VBITS);
            end
            e.addr = s;
            e.last = (s == NVIS - 1);
            q.push_back(e);
        end
        m_cnt = (m_cnt + 1) % (NVIS * LOOPS);
        if (m_cnt == 0) m_blocks++;
    endtask

    always @(posedge clk) begin
        #4;
        if (!rst) begin
            if (q.size() > 0) begin
                check("A valid_o", bus_a.valid_o, 1);
                check("A revis_o", $signed(bus_a.revis_o), q[0].re);
                check("A imvis_o", $signed(bus_a.imvis_o), q[0].im);
                check("A addr_o", bus_a.addr_o, q[0].addr);
                check("A last_o", bus_a.last_o, q[0].last);
                if (bus_a.ready_i) void'(q.pop_front());
            end else begin
                check("A valid_o idle", bus_a.valid_o, 0);
            end
        end
    end

    task automatic drive_a(input bit v, input int re, input int im, input bit rdy);
        @(posedge clk);
        #1;
        bus_a.valid_i = v;
        bus_a.revis_i = ABITS'(re);
        bus_a.imvis_i = ABITS'(im);
        bus_a.ready_i = rdy;
        @(negedge clk);
        if (!rst) begin
            check("A ready_o", bus_a.ready_o, model_drain() ? (q.size() == 0) : 1);
            if (v && bus_a.ready_o) model_accept(re, im);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_a.valid_i = 1'b0;
        bus_b.valid_i = 1'b0;
        bus_c.valid_i = 1'b0;
        @(negedge clk);
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        longint e_re, e_im;
        int     cyc;
        int     c_re [3];
        int     c_im [3];
        c_re = '{-32, 5, 17};
        c_im = '{31, -7, -1};
        bus_a.valid_i = 1'b0; bus_a.revis_i = '0; bus_a.imvis_i = '0; bus_a.ready_i = 1'b1;
        bus_b.valid_i = 1'b0; bus_b.revis_i = '0; bus_b.imvis_i = '0; bus_b.ready_i = 1'b1;
        bus_c.valid_i = 1'b0; bus_c.revis_i = '0; bus_c.imvis_i = '0; bus_c.ready_i = 1'b1;

        do_reset();
        check("rst valid_o", bus_a.valid_o, 0);
        check("rst last_o", bus_a.last_o, 0);
        check("rst addr_o", bus_a.addr_o, 0);
        check("rst revis_o", bus_a.revis_o, 0);
        check("rst imvis_o", bus_a.imvis_o, 0);
        check("rst overflow_o", bus_a.overflow_o, 0);
        check("rst ready_o", bus_a.ready_o, 1);

        // Ramp pattern at full throughput, two blocks
        for (int t = 0; t < 2 * NVIS * LOOPS; t++) drive_a(1'b1, (m_cnt % NVIS) + 1, -1, 1'b1);

        // Downstream stalls at the start of the drain frame
        for (int t = 0; t < 24; t++) drive_a(1'b1, (m_cnt % NVIS) + 1, -1, !(t >= 8 && t < 14));

        // Finish the block, leave its last word pending, then reset mid-block
        while (m_cnt != 0) drive_a(1'b1, (m_cnt % NVIS) + 1, -1, 1'b1);
        for (int t = 0; t < 7; t++) drive_a(1'b1, (m_cnt % NVIS) + 2, 3, 1'b0);
        do_reset();
        check("mid-reset valid_o", bus_a.valid_o, 0);
        check("mid-reset overflow_o", bus_a.overflow_o, 0);
        for (int t = 0; t < NVIS * LOOPS + 2; t++) drive_a(1'b1, 7 - (m_cnt % NVIS), -5, 1'b1);

        // Random gaps on both sides
        m_blocks = 0;
        cyc = 0;
        while (m_blocks < NBLOCKS && cyc < 60000) begin
            drive_a($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)) - 32,
                    int'($urandom_range(0, 63)) - 32, $urandom_range(0, 3) != 0);
            cyc++;
        end
        check("random blocks completed", m_blocks, NBLOCKS);
        for (int t = 0; t < 20; t++) drive_a(1'b0, 0, 0, 1'b1);
        check("A scoreboard empty", q.size(), 0);
        check("A overflow_o", bus_a.overflow_o, 0);

        // Narrow accumulator driven past its range
        e_re = 31;
        e_im = -1;
        for (int k = 1; k < LOOPS_B; k++) begin
            e_re = f_model_add(e_re, 31, VB_B);
            e_im = f_model_add(e_im, -1, VB_B);
        end
        for (int t = 0; t <= NVIS_B * LOOPS_B; t++) begin
            @(posedge clk);
            #1;
            bus_b.valid_i = (t < NVIS_B * LOOPS_B);
            bus_b.revis_i = 6'd31;
            bus_b.imvis_i = 6'h3F;
            bus_b.ready_i = 1'b1;
            @(negedge clk);
            if (t < NVIS_B * LOOPS_B) check("B ready_o", bus_b.ready_o, 1);
            if (t >= NVIS_B * LOOPS_B - 1) begin
                check("B valid_o", bus_b.valid_o, 1);
                check("B revis_o", $signed(bus_b.revis_o), e_re);
                check("B imvis_o", $signed(bus_b.imvis_o), e_im);
                check("B addr_o", bus_b.addr_o, t - (NVIS_B * LOOPS_B - 1));
                check("B last_o", bus_b.last_o, t == NVIS_B * LOOPS_B);
            end
        end
`ifdef VIS_ACCUMULATOR_SATURATE_EN
        check("B overflow_o", bus_b.overflow_o, 1);
`else
        check("B overflow_o", bus_b.overflow_o, 0);
`endif

        // Single-loop instance passes the sign-extended input through
        for (int t = 0; t <= 3; t++) begin
            @(posedge clk);
            #1;
            bus_c.valid_i = (t < 3);
            bus_c.revis_i = ABITS'(c_re[t % 3]);
            bus_c.imvis_i = ABITS'(c_im[t % 3]);
            bus_c.ready_i = 1'b1;
            @(negedge clk);
            check("C ready_o", bus_c.ready_o, 1);
            if (t >= 1) begin
                check("C valid_o", bus_c.valid_o, 1);
                check("C revis_o", $signed(bus_c.revis_o), c_re[t - 1]);
                check("C imvis_o", $signed(bus_c.imvis_o), c_im[t - 1]);
                check("C addr_o", bus_c.addr_o, (t - 1) % 2);
                check("C last_o", bus_c.last_o, ((t - 1) % 2) == 1);
            end
        end
        @(negedge clk);
        check("C valid_o drained", bus_c.valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
